// File: rtl/mmio_uart_rx.sv
// mmio_uart_rx -- memory-mapped 8N1 UART receiver with a receive FIFO.
//
// The serial input is double-synchronised and sampled by a start/data/stop
// FSM. Bytes with a valid stop bit are pushed into a DEPTH-entry FIFO. The
// CPU reads them and a status word over the two-state MMIO handshake.
//
// Ports:
//   clk         core clock, rising edge
//   reset       synchronous, active-high reset
//   uart_rx     asynchronous serial input, idle high
//   req_ready   request can be accepted this cycle
//   req_valid   request present
//   req_addr    byte address; only bit 2 is decoded (0 = DATA, 1 = STATUS)
//   req_wen     1 = write, 0 = read
//   req_wdata   write data (STATUS bit1 clears overrun, bit2 clears frame_err)
//   resp_valid  one-cycle response strobe, one cycle after acceptance
//   resp_rdata  read data captured at acceptance; 0 for writes
module mmio_uart_rx #(
    parameter int unsigned FMAX_MHz = 27,
    parameter int unsigned BAUD     = 115200,
    parameter int unsigned DEPTH    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uart_rx,
    output logic        req_ready,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    input  logic        req_wen,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata
);

    localparam int unsigned CPB   = (FMAX_MHz * 1_000_000) / BAUD;
    localparam int unsigned CW    = $clog2(CPB + 1);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic {BUS_READY, BUS_RESP} bus_state_t;

    // Input synchroniser
    logic r_rx_meta;
    logic r_rx_sync;

    // Receive FSM
    rx_state_t       r_rx_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;

    // FIFO
    logic [7:0]       r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CNT_W-1:0] r_count;

    // Flags and bus
    logic        r_overrun;
    logic        r_frame_err;
    bus_state_t  r_bus_state;
    logic        r_req_ready;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;

    logic        w_expire;
    logic        w_push;
    logic        w_frame_err_set;
    logic        w_accept;
    logic        w_pop;
    logic        w_full;
    logic        w_push_ok;
    logic        w_overrun_set;
    logic        w_clr_overrun;
    logic        w_clr_frame_err;
    logic [31:0] w_rdata;
    logic        w_unused_bits;

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;

    assign w_unused_bits = &{1'b0, req_addr[31:3], req_addr[1:0],
                             req_wdata[31:3], req_wdata[0]};

    // Counter expiry: a load of N acts N cycles later.
    assign w_expire        = (r_cnt == CW'(1));
    assign w_push          = (r_rx_state == RX_STOP) && w_expire && r_rx_sync;
    assign w_frame_err_set = (r_rx_state == RX_STOP) && w_expire && !r_rx_sync;

    assign w_accept        = req_valid && r_req_ready;
    assign w_pop           = w_accept && !req_wen && !req_addr[2] && (r_count != '0);
    assign w_full          = (r_count == CNT_W'(DEPTH));
    // A pop in the same cycle frees the slot the push needs.
    assign w_push_ok       = w_push && (!w_full || w_pop);
    assign w_overrun_set   = w_push && !w_push_ok;
    assign w_clr_overrun   = w_accept && req_wen && req_addr[2] && req_wdata[1];
    assign w_clr_frame_err = w_accept && req_wen && req_addr[2] && req_wdata[2];

    always_comb begin
        w_rdata = '0;
        if (!req_wen) begin
            if (!req_addr[2]) begin
                if (r_count != '0) begin
                    w_rdata = {1'b1, 23'b0, r_mem[r_rptr]};
                end
            end else begin
                w_rdata[0]            = (r_count != '0);
                w_rdata[1]            = r_overrun;
                w_rdata[2]            = r_frame_err;
                w_rdata[8 +: CNT_W]   = r_count;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= uart_rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_state <= RX_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
        end else begin
            case (r_rx_state)
                RX_IDLE: begin
                    if (!r_rx_sync) begin
                        r_cnt      <= CW'(CPB / 2);
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (w_expire) begin
                        if (!r_rx_sync) begin
                            r_cnt      <= CW'(CPB);
                            r_bit_idx  <= '0;
                            r_rx_state <= RX_DATA;
                        end else begin
                            r_rx_state <= RX_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                RX_DATA: begin
                    if (w_expire) begin
                        r_shift <= {r_rx_sync, r_shift[7:1]};
                        r_cnt   <= CW'(CPB);
                        if (r_bit_idx == 3'd7) begin
                            r_rx_state <= RX_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                RX_STOP: begin
                    // Re-arm at mid-stop-bit so back-to-back frames are caught.
                    if (w_expire) begin
                        r_rx_state <= RX_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= r_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push_ok) begin
                r_count <= r_count - CNT_W'(1);
            end
            // Set wins over a simultaneous clear.
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (w_clr_overrun) begin
                r_overrun <= 1'b0;
            end
            if (w_frame_err_set) begin
                r_frame_err <= 1'b1;
            end else if (w_clr_frame_err) begin
                r_frame_err <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bus_state  <= BUS_READY;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            case (r_bus_state)
                BUS_READY: begin
                    if (w_accept) begin
                        r_resp_rdata <= w_rdata;
                        r_resp_valid <= 1'b1;
                        r_req_ready  <= 1'b0;
                        r_bus_state  <= BUS_RESP;
                    end
                end
                BUS_RESP: begin
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_bus_state  <= BUS_READY;
                end
                default: r_bus_state <= BUS_READY;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_rx.sv
// tb_mmio_uart_rx -- scoreboard bench for mmio_uart_rx.
//
// Serial frames and bus requests are driven from one stimulus process. The
// reference model is a byte queue plus two flag bits; every request pushes
// its expected response word into exp_q, and a monitor pops and compares
// whenever resp_valid is seen.
module tb_mmio_uart_rx;

    localparam int unsigned CPB   = 10;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        uart_rx = 1'b1;
    logic        req_ready;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        req_wen = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [31:0] exp_q[$];
    logic [7:0]  model_q[$];
    logic        m_ovr = 1'b0;
    logic        m_ferr = 1'b0;

    mmio_uart_rx #(.FMAX_MHz(1), .BAUD(100000), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .uart_rx    (uart_rx),
        .req_ready  (req_ready),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_wen    (req_wen),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic void model_push(input logic [7:0] b);
        if (model_q.size() < DEPTH) model_q.push_back(b);
        else m_ovr = 1'b1;
    endfunction

    function automatic void model_frame(input logic [7:0] b, input logic stop_bit);
        if (stop_bit) model_push(b);
        else m_ferr = 1'b1;
    endfunction

    function automatic logic [31:0] exp_data_read();
        logic [7:0] b;
        if (model_q.size() == 0) return 32'h0;
        b = model_q.pop_front();
        return 32'h8000_0000 | {24'h0, b};
    endfunction

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s = {16'h0, 8'(model_q.size()), 8'h0};
        s[0] = (model_q.size() != 0);
        s[1] = m_ovr;
        s[2] = m_ferr;
        return s;
    endfunction

    function automatic logic [31:0] exp_status_write(input logic [31:0] wd);
        if (wd[1]) m_ovr = 1'b0;
        if (wd[2]) m_ferr = 1'b0;
        return 32'h0;
    endfunction

    function automatic void model_reset();
        model_q.delete();
        m_ovr = 1'b0;
        m_ferr = 1'b0;
    endfunction

    function automatic logic [31:0] mk_addr(input logic sel);
        return ($urandom() & 32'hFFFF_FFFB) | {29'b0, sel, 2'b0};
    endfunction

    // ---------------- drivers (start and end just after a rising edge) ----------------
    task automatic idle(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        uart_rx = v;
        idle(CPB);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
        uart_rx = 1'b1;
        model_frame(b, stop_bit);
        if (!stop_bit) idle(2 * CPB);
    endtask

    task automatic bus(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp);
        int unsigned t;
        exp_q.push_back(exp);
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wdata;
        t = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            n_checks++;
            $display("FAIL req_ready_timeout: got %b, expected 1", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wdata = $urandom();
        @(negedge clk);
        check("resp_latency", {31'b0, resp_valid}, 32'h1);
        @(posedge clk);
        #1;
        check("resp_one_cycle", {31'b0, resp_valid}, 32'h0);
    endtask

    task automatic rd_data();
        bus(1'b0, mk_addr(1'b0), $urandom(), exp_data_read());
    endtask

    task automatic rd_status();
        bus(1'b0, mk_addr(1'b1), $urandom(), exp_status());
    endtask

    task automatic wr_status(input logic [31:0] wd);
        bus(1'b1, mk_addr(1'b1), wd, exp_status_write(wd));
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (reset === 1'b0 && resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL resp_unexpected: got 0x%08h, expected no response", resp_rdata);
            end else begin
                check("resp_rdata", resp_rdata, exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] b;
        int unsigned r;

        reset = 1'b1;
        idle(3);
        check("reset_req_ready", {31'b0, req_ready}, 32'h1);
        check("reset_resp_valid", {31'b0, resp_valid}, 32'h0);
        check("reset_resp_rdata", resp_rdata, 32'h0);
        reset = 1'b0;
        idle(2);
        rd_status();

        // Single frame, then empty read
        send_frame(8'h5A, 1'b1);
        rd_data();
        rd_data();

        // Back-to-back frames
        send_frame(8'h01, 1'b1);
        send_frame(8'h02, 1'b1);
        send_frame(8'h03, 1'b1);
        rd_status();
        repeat (3) rd_data();

        // Overrun
        for (int i = 0; i < 5; i++) send_frame(8'(8'h10 + i), 1'b1);
        rd_status();
        repeat (4) rd_data();
        wr_status(32'h2);
        rd_status();

        // Framing error, then glitch on idle line
        send_frame(8'hFF, 1'b0);
        rd_status();
        wr_status(32'h4);
        rd_status();
        uart_rx = 1'b0;
        idle(3);
        uart_rx = 1'b1;
        idle(2 * CPB);
        rd_status();

        // Push into full FIFO while a DATA read is accepted in the stop-sample cycle
        for (int i = 0; i < 4; i++) send_frame(8'(8'h20 + i), 1'b1);
        b = 8'($urandom());
        fork
            send_frame(b, 1'b1);
            begin
                idle(97);
                rd_data();
            end
        join
        idle(2);
        rd_status();
        repeat (4) rd_data();

        // Reset during data bit 4 with two bytes queued
        send_frame(8'h33, 1'b1);
        send_frame(8'hCC, 1'b1);
        b = 8'($urandom());
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        uart_rx = b[4];
        idle(5);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        uart_rx = 1'b1;
        model_reset();
        @(negedge clk);
        check("mid_reset_req_ready", {31'b0, req_ready}, 32'h1);
        check("mid_reset_resp_valid", {31'b0, resp_valid}, 32'h0);
        check("mid_reset_resp_rdata", resp_rdata, 32'h0);
        @(posedge clk);
        #1;
        idle(2 * CPB);
        rd_status();
        send_frame(8'hA5, 1'b1);
        rd_data();
        rd_status();

        // Randomized mix of frames and bus traffic
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            if (r <= 3) send_frame(8'($urandom()), ($urandom_range(0, 7) != 0));
            else if (r <= 6) rd_data();
            else if (r == 7) rd_status();
            else if (r == 8) wr_status($urandom());
            else bus(1'b1, mk_addr(1'b0), $urandom(), 32'h0);
        end
        rd_status();
        while (model_q.size() != 0) rd_data();
        rd_status();

        for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL resp_missing: got %0d outstanding, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mmio_uart_rx.md
# mmio_uart_rx

Memory-mapped UART receiver: the receive-side counterpart of the MMIO UART transmitter on the CPU's MMIO bus. It deserializes 8N1 frames from the `uart_rx` pin into an internal FIFO. The CPU reads received bytes and status through the same request/response interface the other MMIO peripherals use. It sits in the MMIO address decoder alongside the TX block, on the same clock.

## Interface
Parameters:
- `FMAX_MHz`, 27: core clock frequency in MHz.
- `BAUD`, 115200: line rate. CPB (clocks per bit) = FMAX_MHz*1_000_000/BAUD, integer division; CPB ≥ 4 is required.
- `DEPTH`, 16: FIFO entries. Must be a power of two, ≤ 128.

Ports:
- `clk`  in  1  core clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `uart_rx`  in  1  serial input, asynchronous, idle high.
- `req_ready`  out  1  block can accept a request this cycle.
- `req_valid`  in  1  request present.
- `req_addr`  in  UIntX  byte address; only bit 2 is decoded.
- `req_wen`  in  1  1 = write, 0 = read.
- `req_wdata`  in  UInt32  write data.
- `resp_valid`  out  1  response strobe.
- `resp_rdata`  out  UInt32  read data; 0 for writes.

## Operation
- Input sync: `uart_rx` passes through two flops before any use; the synced value resets to 1.
- RX FSM:
  - IDLE: on synced line = 0, load the counter with CPB/2 and go to START.
  - START: at count expiry, sample the line. If 0, load CPB, clear the bit index, go to DATA. If 1, treat it as a glitch and return to IDLE with nothing recorded.
  - DATA: at each CPB expiry, sample into the shift register LSB first. After 8 samples, load CPB and go to STOP.
  - STOP: at CPB expiry, sample the line. If 1, push the byte to the FIFO. If 0, discard the byte and set `frame_err`. Either way go to IDLE.
- FIFO push when full: the byte is dropped and `overrun` is set, unless a pop occurs in the same cycle, in which case the push succeeds.
- Register map (addr bit 2):
  - 0x0 DATA, read: if non-empty, returns {1'b1, 23'b0, byte} and pops one entry. If empty, returns 0 and the FIFO is untouched. Writes are ignored.
  - 0x4 STATUS, read: bit0 = not empty, bit1 = `overrun`, bit2 = `frame_err`, bits[15:8] = entry count, other bits 0. Write: bit1 = 1 clears `overrun`, bit2 = 1 clears `frame_err`, other bits ignored.
- Sticky flags: a set event and a clear write in the same cycle leave the flag set.
- Reset:
  - RX FSM returns to IDLE; any frame in progress is lost.
  - FIFO is emptied and both flags are cleared.
  - `req_ready` = 1, `resp_valid` = 0, `resp_rdata` = 0.

## Timing
- Bus FSM, two states:
  - READY: `req_ready` = 1. A request is accepted when `req_valid` && `req_ready`. Read data is captured, the pop or flag clear is applied, and the FSM moves to RESP.
  - RESP: `req_ready` = 0, `resp_valid` = 1 for exactly one cycle with `resp_rdata` stable, then back to READY.
- Latency: response one cycle after acceptance. Maximum throughput is one request per 2 cycles.
- `resp_rdata` holds its last value outside RESP. Only `resp_valid` qualifies it.
- FIFO counts:
  - A pop at acceptance is visible in a STATUS read accepted 2 cycles later.
  - A push in the STOP sample cycle is visible to a request accepted on the next cycle.
  - Simultaneous push and pop leaves the count unchanged; data order is preserved.
- Frame timing: the byte is pushed at 9.5 bit times (± 2 sync cycles) after the start edge. The FSM re-arms at mid-stop-bit, so back-to-back frames with a single stop bit are received.
- Pointers wrap modulo DEPTH. The count ranges 0..DEPTH with no aliasing.

## Test plan
Bench settings: FMAX_MHz = 1, BAUD = 100000 (CPB = 10), DEPTH = 4.
- Single frame: drive byte 0x5A at CPB 10, then read 0x0 → `resp_valid` one cycle after accept, rdata = 0x8000005A. A second read → 0x00000000.
- Back-to-back: bytes 0x01, 0x02, 0x03 with no idle gap → STATUS = 0x00000301. Three DATA reads return 0x01, 0x02, 0x03 in order.
- Overrun: send 5 bytes with no reads → STATUS = 0x00000403. Reads return the first 4 bytes. Write STATUS 0x2 → bit1 cleared.
- Framing and glitch:
  - Frame 0xFF with stop bit = 0 → FIFO empty, STATUS bit2 = 1.
  - A 3-cycle low pulse on idle → no push, no flag.
- Simultaneous push/pop: FIFO full, issue a DATA read accepted in the STOP sample cycle → overrun stays 0, count stays 4, and the new byte is last in order.
- Reset mid-frame: assert `reset` during DATA bit 4 with 2 bytes queued → next cycle `req_ready` = 1, STATUS = 0. A following complete frame 0xA5 is received correctly.
